// File: rtl/task_if_pkg.sv
// ---------------------------------------------------------------------------
// task_if_pkg
// Shared definitions for the task command/status interface:
//   - field widths of the 8-bit status word and the 16-bit op word
//   - opcode values carried on the op bus
//   - Finish argument values
//   - dispatcher FSM state encoding
//   - pack_op(): builds an op word {4'h0, id, opcode, arg}
// ---------------------------------------------------------------------------
package task_if_pkg;

   localparam int ID_W   = 4;
   localparam int PRIO_W = 4;
   localparam int STAT_W = ID_W + PRIO_W;
   localparam int OPC_W  = 4;
   localparam int ARG_W  = 4;
   localparam int OP_W   = 16;

   localparam logic [OPC_W-1:0] OP_READY    = 4'h1;
   localparam logic [OPC_W-1:0] OP_SUSPEND  = 4'h2;
   localparam logic [OPC_W-1:0] OP_WAIT     = 4'h3;
   localparam logic [OPC_W-1:0] OP_KILL     = 4'h4;
   localparam logic [OPC_W-1:0] OP_SETPRIO  = 4'h5;
   localparam logic [OPC_W-1:0] OP_SETEXEHT = 4'h6;
   localparam logic [OPC_W-1:0] OP_EXECUTE  = 4'h7;
   localparam logic [OPC_W-1:0] OP_FINISH   = 4'h8;

   localparam logic [ARG_W-1:0] FIN_DONE    = 4'h0;
   localparam logic [ARG_W-1:0] FIN_PREEMPT = 4'h1;

   localparam logic [OP_W-1:0]  OP_NOP      = 16'h0000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SELECT,
      ST_ISSUE_EXEC,
      ST_RUN,
      ST_ISSUE_FIN,
      ST_NOPGAP
   } state_t;

   function automatic logic [OP_W-1:0] pack_op(
      input logic [ID_W-1:0]  id,
      input logic [OPC_W-1:0] opc,
      input logic [ARG_W-1:0] arg
   );
      return {4'h0, id, opc, arg};
   endfunction

endpackage

// File: rtl/task_prio_select.sv
// ---------------------------------------------------------------------------
// task_prio_select
// Combinational N-way argmax over task status words. A slot is valid when
// its word is non-zero; the valid slot with the largest prio wins and ties go
// to the lowest slot index. The reported id comes from the word itself.
// Ports:
//   i_status  in   N_TASKS*8  status words, slot k = [8k+7:8k] = {id,prio}
//   o_valid   out  1          at least one slot is valid
//   o_idx     out  IDX_W      slot index of the winner
//   o_id      out  ID_W       id field of the winning word
// ---------------------------------------------------------------------------
module task_prio_select
   import task_if_pkg::*;
#(
   parameter int N_TASKS = 8,
   parameter int IDX_W   = 3
) (
   input  logic [N_TASKS*STAT_W-1:0] i_status,
   output logic                      o_valid,
   output logic [IDX_W-1:0]          o_idx,
   output logic [ID_W-1:0]           o_id
);

   logic [PRIO_W-1:0] w_best_prio;
   logic [STAT_W-1:0] w_word;

   always_comb begin
      // NOTE: every variable gets a default before the loop so no path leaves
      // it unassigned; otherwise synthesis infers a latch.
      o_valid     = 1'b0;
      o_idx       = '0;
      o_id        = '0;
      w_best_prio = '0;
      w_word      = '0;
      for (int k = 0; k < N_TASKS; k++) begin
         w_word = i_status[STAT_W*k +: STAT_W];
         // Strict '>' keeps the earlier (lower-index) slot on a tie.
         if (w_word != '0 && (!o_valid || w_word[PRIO_W-1:0] > w_best_prio)) begin
            o_valid     = 1'b1;
            o_idx       = IDX_W'(k);
            o_id        = w_word[STAT_W-1:PRIO_W];
            w_best_prio = w_word[PRIO_W-1:0];
         end
      end
   end

endmodule

// File: rtl/task_dispatcher.sv
// ---------------------------------------------------------------------------
// task_dispatcher
// Scheduler end of the task command/status interface. Picks the
// highest-priority ready task, dispatches it with Execute, enforces a time
// slice, then issues Finish. Host ops are merged onto the same registered op
// bus; every non-NOP op lasts one cycle and is followed by at least one NOP.
// Ports:
//   CLK, RST_N       clock (rising edge), async active-low reset
//   in_sorter        N_TASKS status words {id,prio}; 8'h00 = not ready
//   task_done        1-cycle pulse, running task finished its work
//   host_op/_valid   host command word and offer strobe
//   host_op_ready    host command accepted when valid && ready
//   out_op           op bus {4'h0,id,opcode,arg}; 16'h0000 = NOP
//   running_valid    a task is dispatched
//   running_id       id of the dispatched task
//   dispatch_count   Execute ops issued (wrapping)
//   preempt_count    slice-expiry Finish ops issued (wrapping)
// ---------------------------------------------------------------------------
module task_dispatcher
   import task_if_pkg::*;
#(
   parameter int N_TASKS      = 8,
   parameter int SLICE_CYCLES = 10000,
   parameter int CNT_W        = 16
) (
   input  logic                      CLK,
   input  logic                      RST_N,
   input  logic [N_TASKS*STAT_W-1:0] in_sorter,
   input  logic                      task_done,
   input  logic [OP_W-1:0]           host_op,
   input  logic                      host_op_valid,
   output logic                      host_op_ready,
   output logic [OP_W-1:0]           out_op,
   output logic                      running_valid,
   output logic [ID_W-1:0]           running_id,
   output logic [CNT_W-1:0]          dispatch_count,
   output logic [CNT_W-1:0]          preempt_count
);

   localparam int IDX_W   = (N_TASKS > 1) ? $clog2(N_TASKS) : 1;
   localparam int SLICE_W = $clog2(SLICE_CYCLES);
   localparam logic [SLICE_W-1:0] SLICE_MAX = SLICE_W'(SLICE_CYCLES - 1);

   state_t             r_state,          w_state_nxt;
   logic [OP_W-1:0]    r_out_op,         w_out_op_nxt;
   logic [SLICE_W-1:0] r_slice,          w_slice_nxt;
   logic [IDX_W-1:0]   r_idx,            w_idx_nxt;
   logic [ID_W-1:0]    r_id,             w_id_nxt;
   logic               r_running_valid,  w_running_valid_nxt;
   logic [ID_W-1:0]    r_running_id,     w_running_id_nxt;
   logic [CNT_W-1:0]   r_dispatch_count, w_dispatch_count_nxt;
   logic [CNT_W-1:0]   r_preempt_count,  w_preempt_count_nxt;
   logic               r_done_pend,      w_done_pend_nxt;
   logic [ARG_W-1:0]   r_fin_arg,        w_fin_arg_nxt;

   logic               w_sel_valid;
   logic [IDX_W-1:0]   w_sel_idx;
   logic [ID_W-1:0]    w_sel_id;
   logic [STAT_W-1:0]  w_cur_word;
   logic               w_host_acc;

   task_prio_select #(
      .N_TASKS (N_TASKS),
      .IDX_W   (IDX_W)
   ) u_sel (
      .i_status (in_sorter),
      .o_valid  (w_sel_valid),
      .o_idx    (w_sel_idx),
      .o_id     (w_sel_id)
   );

   // Live status word of the dispatched slot; a drop to zero means the task
   // was killed or suspended behind our back.
   assign w_cur_word = in_sorter[32'(r_idx)*STAT_W +: STAT_W];

   // Gated by RST_N so the port reads 0 while reset is held.
   assign host_op_ready = RST_N && (r_state == ST_IDLE || r_state == ST_RUN)
                          && (r_out_op == OP_NOP) && !r_done_pend;
   assign w_host_acc    = host_op_valid && host_op_ready;

   always_comb begin
      w_state_nxt          = r_state;
      w_out_op_nxt         = OP_NOP;
      w_slice_nxt          = r_slice;
      w_idx_nxt            = r_idx;
      w_id_nxt             = r_id;
      w_running_valid_nxt  = r_running_valid;
      w_running_id_nxt     = r_running_id;
      w_dispatch_count_nxt = r_dispatch_count;
      w_preempt_count_nxt  = r_preempt_count;
      w_done_pend_nxt      = r_done_pend;
      w_fin_arg_nxt        = r_fin_arg;

      // A host op owns the bus for the cycle it is accepted; FSM issue states
      // never coincide with acceptance because ready is low there.
      if (w_host_acc) w_out_op_nxt = host_op;

      unique case (r_state)
         ST_IDLE: begin
            if (!w_host_acc && w_sel_valid) w_state_nxt = ST_SELECT;
         end
         ST_SELECT: begin
            w_idx_nxt   = w_sel_idx;
            w_id_nxt    = w_sel_id;
            w_state_nxt = w_sel_valid ? ST_ISSUE_EXEC : ST_IDLE;
         end
         ST_ISSUE_EXEC: begin
            w_out_op_nxt         = pack_op(r_id, OP_EXECUTE, 4'h0);
            w_running_valid_nxt  = 1'b1;
            w_running_id_nxt     = r_id;
            w_dispatch_count_nxt = r_dispatch_count + CNT_W'(1);
            w_slice_nxt          = '0;
            w_state_nxt          = ST_RUN;
         end
         ST_RUN: begin
            if (task_done || r_done_pend) begin
               if (w_host_acc) begin
                  // Host op goes first; Finish follows after its NOP gap.
                  w_done_pend_nxt = 1'b1;
               end else begin
                  w_done_pend_nxt = 1'b0;
                  w_fin_arg_nxt   = FIN_DONE;
                  w_state_nxt     = ST_ISSUE_FIN;
               end
            end else if (r_slice == SLICE_MAX) begin
               // Slice stays saturated while a host op delays the preempt.
               if (!w_host_acc) begin
                  w_fin_arg_nxt       = FIN_PREEMPT;
                  w_preempt_count_nxt = r_preempt_count + CNT_W'(1);
                  w_state_nxt         = ST_ISSUE_FIN;
               end
            end else if (w_cur_word == '0) begin
               w_running_valid_nxt = 1'b0;
               w_state_nxt         = ST_IDLE;
            end else begin
               w_slice_nxt = r_slice + SLICE_W'(1);
            end
         end
         ST_ISSUE_FIN: begin
            w_out_op_nxt = pack_op(r_id, OP_FINISH, r_fin_arg);
            w_state_nxt  = ST_NOPGAP;
         end
         ST_NOPGAP: begin
            w_running_valid_nxt = 1'b0;
            w_state_nxt         = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state          <= ST_IDLE;
         r_out_op         <= OP_NOP;
         r_slice          <= '0;
         r_idx            <= '0;
         r_id             <= '0;
         r_running_valid  <= 1'b0;
         r_running_id     <= '0;
         r_dispatch_count <= '0;
         r_preempt_count  <= '0;
         r_done_pend      <= 1'b0;
         r_fin_arg        <= FIN_DONE;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values regardless of statement order.
         r_state          <= w_state_nxt;
         r_out_op         <= w_out_op_nxt;
         r_slice          <= w_slice_nxt;
         r_idx            <= w_idx_nxt;
         r_id             <= w_id_nxt;
         r_running_valid  <= w_running_valid_nxt;
         r_running_id     <= w_running_id_nxt;
         r_dispatch_count <= w_dispatch_count_nxt;
         r_preempt_count  <= w_preempt_count_nxt;
         r_done_pend      <= w_done_pend_nxt;
         r_fin_arg        <= w_fin_arg_nxt;
      end
   end

   assign out_op         = r_out_op;
   assign running_valid  = r_running_valid;
   assign running_id     = r_running_id;
   assign dispatch_count = r_dispatch_count;
   assign preempt_count  = r_preempt_count;

endmodule

// File: tb/tb_task_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_task_dispatcher
// Directed bench for task_dispatcher (N_TASKS=8, SLICE_CYCLES=16, CNT_W=16).
// Each scenario task drives the inputs and compares outputs one cycle at a
// time against hand-computed values, sampling 1 time unit after the edge.
// ---------------------------------------------------------------------------
module tb_task_dispatcher;

   logic        CLK;
   logic        RST_N;
   logic [63:0] in_sorter;
   logic        task_done;
   logic [15:0] host_op;
   logic        host_op_valid;
   logic        host_op_ready;
   logic [15:0] out_op;
   logic        running_valid;
   logic [3:0]  running_id;
   logic [15:0] dispatch_count;
   logic [15:0] preempt_count;

   int n_vec = 0;
   int n_err = 0;

   task_dispatcher #(
      .N_TASKS      (8),
      .SLICE_CYCLES (16),
      .CNT_W        (16)
   ) dut (
      .CLK            (CLK),
      .RST_N          (RST_N),
      .in_sorter      (in_sorter),
      .task_done      (task_done),
      .host_op        (host_op),
      .host_op_valid  (host_op_valid),
      .host_op_ready  (host_op_ready),
      .out_op         (out_op),
      .running_valid  (running_valid),
      .running_id     (running_id),
      .dispatch_count (dispatch_count),
      .preempt_count  (preempt_count)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      n_vec++; if (out_op !== 16'h0000) begin n_err++; $display("FAIL rst_out_op: got %h want 0000", out_op); end
      n_vec++; if (running_valid !== 1'b0) begin n_err++; $display("FAIL rst_running_valid: got %b want 0", running_valid); end
      n_vec++; if (running_id !== 4'h0) begin n_err++; $display("FAIL rst_running_id: got %h want 0", running_id); end
      n_vec++; if (dispatch_count !== 16'd0) begin n_err++; $display("FAIL rst_dispatch: got %0d want 0", dispatch_count); end
      n_vec++; if (preempt_count !== 16'd0) begin n_err++; $display("FAIL rst_preempt: got %0d want 0", preempt_count); end
      n_vec++; if (host_op_ready !== 1'b0) begin n_err++; $display("FAIL rst_host_ready: got %b want 0", host_op_ready); end
   endtask

   // slot0=32, slot3=75 -> task 7 wins; Execute 3 edges after the slot shows.
   task automatic test_dispatch();
      in_sorter = 64'h00000000_75000032;
      n_vec++; if (host_op_ready !== 1'b1) begin n_err++; $display("FAIL idle_host_ready: got %b want 1", host_op_ready); end
      step();
      n_vec++; if (out_op !== 16'h0000) begin n_err++; $display("FAIL disp_lat1: got %h want 0000", out_op); end
      step();
      n_vec++; if (out_op !== 16'h0000) begin n_err++; $display("FAIL disp_lat2: got %h want 0000", out_op); end
      step();
      n_vec++; if (out_op !== 16'h0770) begin n_err++; $display("FAIL disp_exec: got %h want 0770", out_op); end
      n_vec++; if (running_valid !== 1'b1) begin n_err++; $display("FAIL disp_rv: got %b want 1", running_valid); end
      n_vec++; if (running_id !== 4'h7) begin n_err++; $display("FAIL disp_id: got %h want 7", running_id); end
      n_vec++; if (dispatch_count !== 16'd1) begin n_err++; $display("FAIL disp_count: got %0d want 1", dispatch_count); end
      n_vec++; if (host_op_ready !== 1'b0) begin n_err++; $display("FAIL disp_ready_busy: got %b want 0", host_op_ready); end
      step();
      n_vec++; if (out_op !== 16'h0000) begin n_err++; $display("FAIL disp_hold1: got %h want 0000", out_op); end
   endtask

   // Continues in RUN cycle 2; task_done lands in RUN cycle 5.
   task automatic test_done();
      repeat (3) step();
      task_done = 1'b1;
      step();
      task_done = 1'b0;
      n_vec++; if (out_op !== 16'h0000) begin n_err++; $display("FAIL done_gap: got %h want 0000", out_op); end
      step();
      n_vec++; if (out_op !== 16'h0780) begin n_err++; $display("FAIL done_fin: got %h want 0780", out_op); end
      n_vec++; if (running_valid !== 1'b1) begin n_err++; $display("FAIL done_rv_fin: got %b want 1", running_valid); end
      in_sorter = '0;
      step();
      n_vec++; if (out_op !== 16'h0000) begin n_err++; $display("FAIL done_nop: got %h want 0000", out_op); end
      n_vec++; if (running_valid !== 1'b0) begin n_err++; $display("FAIL done_rv_fall: got %b want 0", running_valid); end
      n_vec++; if (preempt_count !== 16'd0) begin n_err++; $display("FAIL done_preempt: got %0d want 0", preempt_count); end
   endtask

   // slot1=24, slot5=64: equal prio 4, lowest index (id 2) wins. Then slot1
   // drops mid-RUN: no Finish, back to IDLE, slot5 (id 6) dispatched.
   task automatic test_tie_and_drop();
      in_sorter = 64'h00006400_00002400;
      repeat (3) step();
      n_vec++; if (out_op !== 16'h0270) begin n_err++; $display("FAIL tie_exec: got %h want 0270", out_op); end
      n_vec++; if (dispatch_count !== 16'd2) begin n_err++; $display("FAIL tie_count: got %0d want 2", dispatch_count); end
      in_sorter = 64'h00006400_00000000;
      step();
      n_vec++; if (running_valid !== 1'b0) begin n_err++; $display("FAIL drop_rv: got %b want 0", running_valid); end
      n_vec++; if (out_op !== 16'h0000) begin n_err++; $display("FAIL drop_no_fin: got %h want 0000", out_op); end
      repeat (3) step();
      n_vec++; if (out_op !== 16'h0670) begin n_err++; $display("FAIL drop_redisp: got %h want 0670", out_op); end
      n_vec++; if (running_id !== 4'h6) begin n_err++; $display("FAIL drop_id: got %h want 6", running_id); end
      in_sorter = '0;
      step();
      n_vec++; if (running_valid !== 1'b0) begin n_err++; $display("FAIL drop2_rv: got %b want 0", running_valid); end
   endtask

   // 16 RUN cycles without done -> Finish/preempt, then re-dispatch of task 7.
   task automatic test_preempt();
      logic early_op;
      early_op = 1'b0;
      in_sorter = 64'h00000000_75000032;
      repeat (3) step();
      n_vec++; if (out_op !== 16'h0770) begin n_err++; $display("FAIL pre_exec: got %h want 0770", out_op); end
      for (int i = 0; i < 16; i++) begin
         step();
         if (out_op !== 16'h0000) early_op = 1'b1;
      end
      n_vec++; if (early_op !== 1'b0) begin n_err++; $display("FAIL pre_early: got op before slice end, want none"); end
      step();
      n_vec++; if (out_op !== 16'h0781) begin n_err++; $display("FAIL pre_fin: got %h want 0781", out_op); end
      n_vec++; if (preempt_count !== 16'd1) begin n_err++; $display("FAIL pre_count: got %0d want 1", preempt_count); end
      step();
      n_vec++; if (running_valid !== 1'b0) begin n_err++; $display("FAIL pre_rv_fall: got %b want 0", running_valid); end
      repeat (3) step();
      n_vec++; if (out_op !== 16'h0770) begin n_err++; $display("FAIL pre_redisp: got %h want 0770", out_op); end
      n_vec++; if (dispatch_count !== 16'd5) begin n_err++; $display("FAIL pre_disp_count: got %0d want 5", dispatch_count); end
   endtask

   // Host op and task_done together in RUN -> 0352, NOP, 0780.
   task automatic test_host_done();
      step();
      n_vec++; if (host_op_ready !== 1'b1) begin n_err++; $display("FAIL hd_ready: got %b want 1", host_op_ready); end
      host_op = 16'h0352; host_op_valid = 1'b1; task_done = 1'b1;
      step();
      host_op_valid = 1'b0; task_done = 1'b0; host_op = 16'h0000;
      n_vec++; if (out_op !== 16'h0352) begin n_err++; $display("FAIL hd_host: got %h want 0352", out_op); end
      n_vec++; if (host_op_ready !== 1'b0) begin n_err++; $display("FAIL hd_ready_pend: got %b want 0", host_op_ready); end
      step();
      n_vec++; if (out_op !== 16'h0000) begin n_err++; $display("FAIL hd_gap: got %h want 0000", out_op); end
      step();
      n_vec++; if (out_op !== 16'h0780) begin n_err++; $display("FAIL hd_fin: got %h want 0780", out_op); end
      in_sorter = '0;
      step();
      n_vec++; if (out_op !== 16'h0000) begin n_err++; $display("FAIL hd_nop: got %h want 0000", out_op); end
      n_vec++; if (running_valid !== 1'b0) begin n_err++; $display("FAIL hd_rv: got %b want 0", running_valid); end
      n_vec++; if (preempt_count !== 16'd1) begin n_err++; $display("FAIL hd_preempt: got %0d want 1", preempt_count); end
   endtask

   // Host op in IDLE: passes through for exactly one cycle.
   task automatic test_host_idle();
      step();
      host_op = 16'h0145; host_op_valid = 1'b1;
      step();
      host_op_valid = 1'b0; host_op = 16'h0000;
      n_vec++; if (out_op !== 16'h0145) begin n_err++; $display("FAIL hi_op: got %h want 0145", out_op); end
      step();
      n_vec++; if (out_op !== 16'h0000) begin n_err++; $display("FAIL hi_nop: got %h want 0000", out_op); end
      n_vec++; if (running_valid !== 1'b0) begin n_err++; $display("FAIL hi_rv: got %b want 0", running_valid); end
   endtask

   // Async reset asserted mid-RUN; outputs clear before the next edge.
   task automatic test_reset_mid_run();
      in_sorter = 64'h00000000_75000032;
      repeat (3) step();
      n_vec++; if (dispatch_count !== 16'd6) begin n_err++; $display("FAIL mr_pre_count: got %0d want 6", dispatch_count); end
      repeat (2) step();
      #3 RST_N = 1'b0;
      #1;
      n_vec++; if (out_op !== 16'h0000) begin n_err++; $display("FAIL mr_out_op: got %h want 0000", out_op); end
      n_vec++; if (running_valid !== 1'b0) begin n_err++; $display("FAIL mr_rv: got %b want 0", running_valid); end
      n_vec++; if (dispatch_count !== 16'd0) begin n_err++; $display("FAIL mr_dispatch: got %0d want 0", dispatch_count); end
      n_vec++; if (preempt_count !== 16'd0) begin n_err++; $display("FAIL mr_preempt: got %0d want 0", preempt_count); end
      n_vec++; if (running_id !== 4'h0) begin n_err++; $display("FAIL mr_id: got %h want 0", running_id); end
   endtask

   initial begin
      RST_N = 1'b0;
      in_sorter = '0;
      task_done = 1'b0;
      host_op = 16'h0000;
      host_op_valid = 1'b0;
      #12;
      test_reset();
      @(negedge CLK);
      RST_N = 1'b1;
      step();
      test_dispatch();
      test_done();
      step();
      test_tie_and_drop();
      test_preempt();
      test_host_done();
      test_host_idle();
      test_reset_mid_run();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: run did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
